glm_bram_arbiter: RTL and testbench
===================================

// Module: glm_bram_arbiter
// PURPOSE
//  Shares one 512-bit cache-line BRAM port (bram_write / bram_request / bram_read) between
//  NUM_CLIENTS engines (program fetch, prefetcher, update unit). Round-robin grant, one op per
//  cycle, registered issue to the BRAM; read data is routed back to the issuing client in order.
// PARAMETERS
//  NUM_CLIENTS       4   number of requesters (2..8)
//  LOG2_TAG_DEPTH    3   log2 of outstanding-read tag FIFO depth (>= BRAM read latency + 2)
//  DRAIN_CYCLES      4   cycles after reset during which BRAM read.valid is discarded silently
// PORTS
//  clk               in   1                        clock
//  reset             in   1                        synchronous, active-high
//  cl_write          in   bram_write  [NUM_CLIENTS] per-client write command (we = valid)
//  cl_request        in   bram_request[NUM_CLIENTS] per-client read command (re = valid)
//  cl_grant          out  NUM_CLIENTS              one-hot, combinational: command accepted this cycle
//  cl_read           out  bram_read   [NUM_CLIENTS] per-client read return (valid + 512b data)
//  mem_write         out  bram_write               to BRAM, registered
//  mem_request       out  bram_request             to BRAM, registered
//  mem_read          in   bram_read                from BRAM, any fixed or variable in-order latency
//  outstanding       out  LOG2_TAG_DEPTH+1         reads issued but not yet returned
//  err_orphan        out  1                        sticky: read.valid with no outstanding tag
// BEHAVIOUR
//  - Reset: mem_write.we=0, mem_request.re=0, all cl_read.valid=0, cl_grant=0, rr pointer=0,
//    tag FIFO empty, outstanding=0, err_orphan=0, drain counter=DRAIN_CYCLES.
//  - Client handshake: client holds we or re (and address/data) stable until cl_grant[i]=1 in
//    the same cycle; it may present the next command in the following cycle. Dropping a
//    command before grant is legal (withdrawn, never issued).
//  - Client eligible if we | (re & ~tag_full). Both we and re set: write is taken first; read
//    remains pending and competes again next cycle.
//  - Round robin: search starts at rr+1 (mod NUM_CLIENTS); on grant to i, rr <= i. No grant -> rr held.
//    Any continuously requesting client is granted within NUM_CLIENTS cycles.
//  - Issue: granted command registered to mem_write/mem_request at t+1 for exactly one cycle;
//    we and re never both high at the BRAM. Non-granted cycles drive we=re=0.
//  - Tags: each issued read pushes client id into tag FIFO at issue (t+1). Each mem_read.valid
//    pops head id j; cl_read[j] <= mem_read registered (valid one cycle, t_return+1); all other
//    cl_read[*].valid = 0. Read latency client-visible = 1 + BRAM latency + 1.
//  - tag_full = (count == 2**LOG2_TAG_DEPTH) evaluated with simultaneous pop credited
//    (pop and push same cycle at full is allowed). outstanding = FIFO count.
//  - Ordering: issue order is BRAM order; write then read of same address from different
//    clients on consecutive grants returns new data if BRAM is write-first (arbiter adds no bypass).
//  - Orphan: mem_read.valid with empty FIFO and drain counter == 0 -> err_orphan <= 1 (sticky
//    until reset), data dropped. While drain counter > 0, valid is dropped without flag; counter
//    decrements each cycle (covers reads in flight across a mid-operation reset).
//  - Reset mid-operation: pending commands and tags discarded; clients must reissue.
// STRUCTURE
//  - Shared package glm_common: bram_write/bram_request/bram_read, LOG2_MEMORY_SIZE; add
//    typedef t_client_id (logic[$clog2(NUM_CLIENTS)-1:0]) and constant ARB_MAX_CLIENTS = 8.
//  - Sub-module glm_tag_fifo: sync FIFO, width $clog2(NUM_CLIENTS), depth 2**LOG2_TAG_DEPTH,
//    push/pop same cycle, count + full/empty outputs, synchronous reset.
//  - Top: rr pointer + priority rotate (combinational), issue registers, return demux register.
// TESTING
//  - Single client 1 read addr 0x005, BRAM latency 2 -> mem_request.re at t+1, cl_read[1].valid at t+4.
//  - All 4 clients request reads every cycle for 16 cycles -> grants 1,2,3,0,1... each client 4 reads,
//    returns in grant order to correct client, outstanding never exceeds 8.
//  - Client 2 asserts we and re same cycle addr 0x3FF -> write issued at t+1, read at t+2 returns new data.
//  - Stall BRAM returns with 8 reads outstanding -> no read grants, write from client 0 still granted;
//    return + new read same cycle at full -> both accepted, outstanding stays 8.
//  - Reset with 3 reads in flight -> returns within DRAIN_CYCLES dropped, err_orphan=0; inject
//    spurious valid after drain -> err_orphan=1 and remains 1.
//  - Client withdraws re before grant -> no BRAM issue, no tag pushed, rr unchanged.

Source files
------------

// File: rtl/glm_common_pkg.sv
// Shared BRAM cache-line bus types and sizing for the glm engines.
package glm_common;

  localparam int unsigned LOG2_MEMORY_SIZE = 10;
  localparam int unsigned LINE_W           = 512;
  localparam int unsigned ARB_MAX_CLIENTS  = 8;

  typedef logic [$clog2(ARB_MAX_CLIENTS)-1:0] t_client_id;

  typedef struct packed {
    logic                        we;
    logic [LOG2_MEMORY_SIZE-1:0] addr;
    logic [LINE_W-1:0]           data;
  } bram_write;

  typedef struct packed {
    logic                        re;
    logic [LOG2_MEMORY_SIZE-1:0] addr;
  } bram_request;

  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] data;
  } bram_read;

endpackage

// File: rtl/glm_tag_fifo.sv
// Synchronous FIFO of client ids for reads in flight; push and pop allowed in the same cycle.
module glm_tag_fifo #(
  parameter int unsigned W          = 2,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_push,
  input  logic [W-1:0]        i_data,
  input  logic                i_pop,
  output logic [W-1:0]        o_data,
  output logic [LOG2_DEPTH:0] o_count,
  output logic                o_full,
  output logic                o_empty
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

  logic [W-1:0]          r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr;
  logic [LOG2_DEPTH-1:0] r_rd;
  logic [LOG2_DEPTH:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == (LOG2_DEPTH + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + LOG2_DEPTH'(1);
      if (w_do_pop)  r_rd <= r_rd + LOG2_DEPTH'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (LOG2_DEPTH + 1)'(1);
        2'b01:   r_count <= r_count - (LOG2_DEPTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/glm_bram_arbiter.sv
// Round-robin arbiter sharing one cache-line BRAM port; read data is steered back by id tags.
module glm_bram_arbiter
  import glm_common::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned LOG2_TAG_DEPTH = 3,
  parameter int unsigned DRAIN_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  bram_write                cl_write   [NUM_CLIENTS],
  input  bram_request              cl_request [NUM_CLIENTS],
  output logic [NUM_CLIENTS-1:0]   cl_grant,
  output bram_read                 cl_read    [NUM_CLIENTS],
  output bram_write                mem_write,
  output bram_request              mem_request,
  input  bram_read                 mem_read,
  output logic [LOG2_TAG_DEPTH:0]  outstanding,
  output logic                     err_orphan
);

  localparam int unsigned ID_W    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [ID_W-1:0]          r_rr;
  logic [DRAIN_W-1:0]       r_drain;
  bram_write                r_mem_write;
  bram_request              r_mem_request;
  logic [NUM_CLIENTS-1:0]   r_ret_valid;
  logic [LINE_W-1:0]        r_ret_data;
  logic                     r_err;

  logic [NUM_CLIENTS-1:0]   w_eligible;
  logic [NUM_CLIENTS-1:0]   w_grant;
  logic [ID_W-1:0]          w_grant_id;
  logic                     w_any;
  logic                     w_grant_write;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_tag_full;
  logic                     w_tag_empty;
  logic [ID_W-1:0]          w_tag_head;
  logic [LOG2_TAG_DEPTH:0]  w_tag_count;
  int unsigned              w_idx;

  assign w_pop      = mem_read.valid & ~w_tag_empty;
  assign w_tag_full = w_fifo_full & ~w_pop;

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++)
      w_eligible[i] = cl_write[i].we | (cl_request[i].re & ~w_tag_full);
  end

  // Rotating priority: first eligible client after the last winner.
  always_comb begin
    w_any      = 1'b0;
    w_grant_id = r_rr;
    w_idx      = 0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      w_idx = (32'(r_rr) + k) % NUM_CLIENTS;
      if (!w_any && w_eligible[ID_W'(w_idx)]) begin
        w_any      = 1'b1;
        w_grant_id = ID_W'(w_idx);
      end
    end
    if (reset) w_any = 1'b0;
    w_grant = w_any ? (NUM_CLIENTS'(1) << w_grant_id) : '0;
  end

  assign w_grant_write = cl_write[w_grant_id].we;
  assign w_push        = w_any & ~w_grant_write;

  glm_tag_fifo #(
    .W          (ID_W),
    .LOG2_DEPTH (LOG2_TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_grant_id),
    .i_pop   (w_pop),
    .o_data  (w_tag_head),
    .o_count (w_tag_count),
    .o_full  (w_fifo_full),
    .o_empty (w_tag_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr          <= '0;
      r_drain       <= DRAIN_W'(DRAIN_CYCLES);
      r_mem_write   <= '0;
      r_mem_request <= '0;
      r_ret_valid   <= '0;
      r_ret_data    <= '0;
      r_err         <= 1'b0;
    end else begin
      r_mem_write   <= '0;
      r_mem_request <= '0;
      r_ret_valid   <= '0;
      if (w_any) begin
        r_rr <= w_grant_id;
        if (w_grant_write) r_mem_write   <= cl_write[w_grant_id];
        else               r_mem_request <= cl_request[w_grant_id];
      end
      if (w_pop) begin
        r_ret_valid <= NUM_CLIENTS'(1) << w_tag_head;
        r_ret_data  <= mem_read.data;
      end
      // Returns with no tag are stale leftovers during drain, otherwise a protocol error.
      if (mem_read.valid && w_tag_empty && (r_drain == '0)) r_err <= 1'b1;
      if (r_drain != '0) r_drain <= r_drain - DRAIN_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++)
      cl_read[i] = '{valid: r_ret_valid[i], data: r_ret_data};
  end

  assign cl_grant    = w_grant;
  assign mem_write   = r_mem_write;
  assign mem_request = r_mem_request;
  assign outstanding = w_tag_count;
  assign err_orphan  = r_err;

endmodule

// File: tb/tb_glm_bram_arbiter.sv
// Scoreboard bench for glm_bram_arbiter with a behavioural BRAM and arbitration reference model.
module tb_glm_bram_arbiter;
  import glm_common::*;

  localparam int NC    = 4;
  localparam int L2T   = 3;
  localparam int DRAIN = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  bram_write   cl_write   [NC];
  bram_request cl_request [NC];
  logic [NC-1:0] cl_grant;
  bram_read    cl_read    [NC];
  bram_write   mem_write;
  bram_request mem_request;
  bram_read    mem_read;
  logic [L2T:0] outstanding;
  logic        err_orphan;

  always #5 clk = ~clk;

  glm_bram_arbiter #(.NUM_CLIENTS(NC), .LOG2_TAG_DEPTH(L2T), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .cl_write(cl_write), .cl_request(cl_request),
    .cl_grant(cl_grant), .cl_read(cl_read), .mem_write(mem_write),
    .mem_request(mem_request), .mem_read(mem_read),
    .outstanding(outstanding), .err_orphan(err_orphan));

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [511:0] act, logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Scoreboard of expected read returns, in grant order
  typedef struct { int id; logic [511:0] data; int unsigned due; bit chk; } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    int nv;
    exp_t e;
    nv = 0;
    if (reset === 1'b0) begin
      for (int i = 0; i < NC; i++) if (cl_read[i].valid) nv++;
      if (nv > 1) check("ret_onehot", 512'(nv), 512'(1));
      for (int i = 0; i < NC; i++) begin
        if (cl_read[i].valid) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL ret_unexpected got client=%0d want no return", i);
          end else begin
            e = sb.pop_front();
            check("ret_client", 512'(i), 512'(e.id));
            check("ret_data", cl_read[i].data, e.data);
            if (e.chk) check("ret_cycle", 512'(cyc), 512'(e.due));
          end
        end
      end
    end
  end

  // Behavioural in-order BRAM, write-first, with optional stall and spurious-valid injection
  typedef struct { logic [511:0] d; int unsigned due; } rd_t;
  logic [511:0] bmem [1024];
  rd_t          bq[$];
  bit           stall, inject;
  int           lat_min, lat_max;
  int unsigned  last_due;

  task automatic bram_tick();
    rd_t r;
    int unsigned due;
    mem_read.valid = 1'b0;
    mem_read.data  = '0;
    if (inject) begin
      mem_read.valid = 1'b1;
      mem_read.data  = rnd512();
      inject = 0;
    end else if (!stall && bq.size() > 0 && bq[0].due <= cyc) begin
      r = bq.pop_front();
      mem_read.valid = 1'b1;
      mem_read.data  = r.d;
    end
    if (mem_write.we) bmem[mem_write.addr] = mem_write.data;
    if (mem_request.re) begin
      due = cyc + 32'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      bq.push_back('{bmem[mem_request.addr], due});
    end
  endtask

  // Client commands and reference model state
  bit           p_we [NC], p_re [NC];
  logic [9:0]   p_waddr [NC], p_raddr [NC];
  logic [511:0] p_wdata [NC];
  logic [511:0] shadow [1024];
  int           m_rr, m_count, m_drain, fixed_lat;
  bit           m_err, lat_chk, x_we, x_re;
  logic [9:0]   x_addr;
  logic [511:0] x_data;

  task automatic step(bit rst);
    bit pop, full;
    int g, idx;
    logic [NC-1:0] exp_g;
    @(negedge clk);
    check("mem_we", 512'(mem_write.we), 512'(x_we));
    if (x_we) begin
      check("mem_waddr", 512'(mem_write.addr), 512'(x_addr));
      check("mem_wdata", mem_write.data, x_data);
    end
    check("mem_re", 512'(mem_request.re), 512'(x_re));
    if (x_re) check("mem_raddr", 512'(mem_request.addr), 512'(x_addr));
    check("outstanding", 512'(outstanding), 512'(m_count));
    check("err_orphan", 512'(err_orphan), 512'(m_err));
    bram_tick();
    #1;
    reset = rst;
    for (int i = 0; i < NC; i++) begin
      cl_write[i].we     = p_we[i];
      cl_write[i].addr   = p_waddr[i];
      cl_write[i].data   = p_wdata[i];
      cl_request[i].re   = p_re[i];
      cl_request[i].addr = p_raddr[i];
    end
    #1;
    pop  = mem_read.valid && (m_count > 0);
    full = (m_count == DEPTH) && !pop;
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= NC; k++) begin
        idx = (m_rr + k) % NC;
        if (g < 0 && (p_we[idx] || (p_re[idx] && !full))) g = idx;
      end
    end
    exp_g = (g >= 0) ? NC'(1) << g : '0;
    check("grant", 512'(cl_grant), 512'(exp_g));
    x_we = 0;
    x_re = 0;
    if (rst) begin
      m_rr = 0; m_count = 0; m_drain = DRAIN; m_err = 0;
      sb.delete();
      for (int i = 0; i < NC; i++) begin p_we[i] = 0; p_re[i] = 0; end
    end else begin
      if (mem_read.valid && m_count == 0 && m_drain == 0) m_err = 1;
      if (m_drain > 0) m_drain--;
      if (pop) m_count--;
      if (g >= 0) begin
        m_rr = g;
        if (p_we[g]) begin
          x_we = 1; x_addr = p_waddr[g]; x_data = p_wdata[g];
          shadow[p_waddr[g]] = p_wdata[g];
          p_we[g] = 0;
        end else begin
          x_re = 1; x_addr = p_raddr[g];
          m_count++;
          sb.push_back('{g, shadow[p_raddr[g]], cyc + 32'(fixed_lat) + 2, lat_chk});
          p_re[g] = 0;
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic set_read(int c, logic [9:0] a);
    p_re[c] = 1; p_raddr[c] = a;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = '0;
    stall = 0; inject = 0; last_due = 0;
    lat_min = 2; lat_max = 2; fixed_lat = 2; lat_chk = 1;
    m_rr = 0; m_count = 0; m_drain = DRAIN; m_err = 0; x_we = 0; x_re = 0;
    x_addr = '0; x_data = '0;
    for (int i = 0; i < 1024; i++) begin bmem[i] = '0; shadow[i] = '0; end
    for (int i = 0; i < NC; i++) begin
      p_we[i] = 0; p_re[i] = 0; p_waddr[i] = '0; p_raddr[i] = '0; p_wdata[i] = '0;
    end
    step(1); step(1); step(1);
    idle(4);

    // single read, latency 2
    set_read(1, 10'h005);
    idle(8);

    // all clients read back-to-back
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < NC; i++) if (!p_re[i]) set_read(i, 10'($urandom_range(1023)));
      step(0);
    end
    for (int i = 0; i < NC; i++) p_re[i] = 0;
    idle(8);

    // write and read of the same line from one client in one cycle
    p_we[2] = 1; p_waddr[2] = 10'h3FF; p_wdata[2] = rnd512();
    set_read(2, 10'h3FF);
    idle(8);

    // stalled returns: fill tags, writes still pass, return+read at full
    stall = 1; lat_chk = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NC; i++) if (!p_re[i]) set_read(i, 10'($urandom_range(1023)));
      if (c == 10) begin p_we[0] = 1; p_waddr[0] = 10'h010; p_wdata[0] = rnd512(); end
      step(0);
    end
    stall = 0;
    step(0);
    stall = 1;
    idle(2);
    stall = 0;
    for (int i = 0; i < NC; i++) p_re[i] = 0;
    idle(24);

    // reset with reads in flight, then drain and a spurious return
    lat_min = 3; lat_max = 3;
    set_read(0, 10'h020); set_read(1, 10'h021); set_read(2, 10'h022);
    idle(3);
    step(1); step(1);
    idle(7);
    inject = 1;
    idle(4);

    // withdrawn request leaves the pointer alone
    set_read(1, 10'h030); set_read(2, 10'h031);
    step(0);
    p_re[2] = 0;
    step(0);
    set_read(0, 10'h032); set_read(2, 10'h033);
    idle(10);

    // randomized traffic with variable latency and stalls
    step(1); step(1);
    idle(5);
    lat_min = 1; lat_max = 4;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(4) == 0);
      for (int i = 0; i < NC; i++) begin
        if (!p_we[i] && $urandom_range(3) == 0) begin
          p_we[i] = 1; p_waddr[i] = 10'($urandom_range(15)); p_wdata[i] = rnd512();
        end else if (p_we[i] && $urandom_range(15) == 0) p_we[i] = 0;
        if (!p_re[i] && $urandom_range(2) == 0) set_read(i, 10'($urandom_range(15)));
        else if (p_re[i] && $urandom_range(9) == 0) p_re[i] = 0;
      end
      step(0);
    end
    stall = 0;
    for (int i = 0; i < NC; i++) begin p_we[i] = 0; p_re[i] = 0; end
    for (int c = 0; c < 100 && (sb.size() > 0 || bq.size() > 0); c++) step(0);
    idle(3);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
